// File: rtl/uart_rx_fsm.sv
// UART 8N1 receiver running entirely on hwclk.
// The RX line is synchronised, a start edge phase-aligns an internal
// oversampling divider, and each bit is sampled at its centre. Received
// bytes leave on a valid/ready handshake alongside framing-error and
// overrun pulses.
module uart_rx_fsm #(
    parameter int CNTR_W      = 32,
    parameter int SOURCE_CLK  = 12000000,
    parameter int TARGET_CLK  = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int FRAME_WIDTH = 8
) (
    input  logic                   hwclk,
    input  logic                   rst,
    input  logic                   ftdi_rx,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   rx_active
);

    localparam int DIV   = SOURCE_CLK / (TARGET_CLK * OVERSAMPLE);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

    localparam logic [CNTR_W-1:0] DIV_LAST = CNTR_W'(DIV - 1);
    localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic                   rx_meta_r;
    logic                   rx_s_r;
    logic                   rx_prev_r;
    logic [CNTR_W-1:0]      div_cnt_r;
    logic [OS_W-1:0]        os_cnt_r;
    logic [BIT_W-1:0]       bit_cnt_r;
    logic [1:0]             state_r;
    logic [FRAME_WIDTH-1:0] shreg_r;

    logic       tick_s;
    logic       fall_s;
    logic [1:0] state_nxt_s;
    logic       start_s;
    logic       os_clr_s;
    logic       os_inc_s;
    logic       bit_inc_s;
    logic       bit_clr_s;
    logic       shift_s;
    logic       load_s;
    logic       ferr_s;

    // Next-state and per-cycle event decode for the receive FSM.
    always_comb begin
        tick_s      = (div_cnt_r == DIV_LAST);
        fall_s      = rx_prev_r & ~rx_s_r;
        state_nxt_s = state_r;
        start_s     = 1'b0;
        os_clr_s    = 1'b0;
        os_inc_s    = 1'b0;
        bit_inc_s   = 1'b0;
        bit_clr_s   = 1'b0;
        shift_s     = 1'b0;
        load_s      = 1'b0;
        ferr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Only a true high-to-low transition arms the receiver, so a
                // line held in break after a framing error stays ignored.
                if (fall_s) begin
                    state_nxt_s = ST_START;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (os_cnt_r == OS_MID)) begin
                    os_clr_s    = 1'b1;
                    state_nxt_s = rx_s_r ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    os_inc_s = 1'b1;
                end else begin
                    os_inc_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (tick_s && (os_cnt_r == OS_LAST)) begin
                    os_clr_s = 1'b1;
                    shift_s  = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_clr_s   = 1'b1;
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_inc_s = 1'b1;
                    end
                end else if (tick_s) begin
                    os_inc_s = 1'b1;
                end else begin
                    os_inc_s = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick_s && (os_cnt_r == OS_LAST)) begin
                    os_clr_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                    if (rx_s_r) begin
                        load_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else if (tick_s) begin
                    os_inc_s = 1'b1;
                end else begin
                    os_inc_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Two-flop synchroniser on the async RX line plus previous sample for edge detect.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= ftdi_rx;
            rx_s_r    <= rx_meta_r;
            rx_prev_r <= rx_s_r;
        end
    end

    // Oversample tick divider, re-phased to the start edge.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            div_cnt_r <= {CNTR_W{1'b0}};
        end else if (start_s || tick_s) begin
            div_cnt_r <= {CNTR_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + CNTR_W'(1);
        end
    end

    // Sample-within-bit and bit-within-frame counters.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            os_cnt_r  <= {OS_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
        end else begin
            if (start_s || os_clr_s) begin
                os_cnt_r <= {OS_W{1'b0}};
            end else if (os_inc_s) begin
                os_cnt_r <= os_cnt_r + OS_W'(1);
            end else begin
                os_cnt_r <= os_cnt_r;
            end
            if (start_s || bit_clr_s) begin
                bit_cnt_r <= {BIT_W{1'b0}};
            end else if (bit_inc_s) begin
                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // FSM state register and LSB-first deserialiser.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            shreg_r <= {FRAME_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (shift_s) begin
                shreg_r <= {rx_s_r, shreg_r[FRAME_WIDTH-1:1]};
            end else begin
                shreg_r <= shreg_r;
            end
        end
    end

    // Registered handshake, status pulses and activity flag.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            rx_data   <= {FRAME_WIDTH{1'b0}};
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_active <= 1'b0;
        end else begin
            frame_err <= ferr_s;
            // Overwriting is only an overrun when the old byte is not being taken this cycle.
            overrun   <= load_s & rx_valid & ~rx_ready;
            rx_active <= (state_nxt_s != ST_IDLE);
            if (load_s) begin
                rx_data  <= shreg_r;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_data  <= rx_data;
                rx_valid <= 1'b0;
            end else begin
                rx_data  <= rx_data;
                rx_valid <= rx_valid;
            end
        end
    end

endmodule
